// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_decoder
// Purpose  : Turns the raw PS/2 scan-code byte stream into game key state.
//            Tracks make/break (F0) and extended (E0) prefixes, reports
//            held direction flags (WASD or arrow keys), one-cycle move
//            pulses with an initial delay and auto-repeat, and the most
//            recent make code for the HEX display.
// Ports    : CLOCK_50          - system clock
//            reset             - synchronous, active-high
//            received_data     - scan-code byte
//            received_data_en  - one-cycle strobe, received_data valid
//            *_held            - direction currently held
//            move_*            - one-cycle move pulse
//            last_make/last_ext- last accepted make code and its E0 flag
//            make_strobe       - pulses when last_make/last_ext update
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_decoder #(
    parameter int CNT_W          = 24,
    parameter int FIRST_DELAY    = 12_500_000,
    parameter int REPEAT_CYCLES  = 2_500_000,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic       up_held,
    output logic       down_held,
    output logic       left_held,
    output logic       right_held,
    output logic       move_up,
    output logic       move_down,
    output logic       move_left,
    output logic       move_right,
    output logic [7:0] last_make,
    output logic       last_ext,
    output logic       make_strobe
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_first_delay  = CNT_W'(FIRST_DELAY);
    localparam logic [CNT_W-1:0] c_repeat       = CNT_W'(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_one          = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_idle_cnt;
    logic [CNT_W-1:0] r_rep_cnt;
    // One bit per physical key. [3:0] = W,S,A,D and [7:4] = arrow up,down,
    // left,right, so direction d is simply bit d OR bit d+4.
    logic [7:0]       r_keys;
    logic [3:0]       r_move;     // {right, left, down, up}

    logic       w_ignored;
    logic       w_make;
    logic       w_break;
    logic       w_ext;
    logic [7:0] w_key_hit;
    logic [7:0] w_keys_next;
    logic [3:0] w_dir_cur;
    logic [3:0] w_dir_next;
    logic [3:0] w_new_dir;
    logic [3:0] w_pulse;
    logic       w_any_next;
    logic       w_expire;
    logic       w_ud_both;
    logic       w_lr_both;

    // Keyboard status/ack bytes that must never be taken as key codes.
    always_comb begin
        w_ignored = 1'b0;
        case (received_data)
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: w_ignored = 1'b1;
            default: w_ignored = 1'b0;
        endcase
    end

    // Classify the current byte as a make/break event given the prefix state.
    always_comb begin
        w_make  = 1'b0;
        w_break = 1'b0;
        w_ext   = 1'b0;
        if (received_data_en) begin
            case (r_state)
                ST_IDLE: begin
                    w_make = (received_data != 8'hE0) && (received_data != 8'hF0) && !w_ignored;
                end
                ST_EXT: begin
                    w_make = (received_data != 8'hE0) && (received_data != 8'hF0);
                    w_ext  = 1'b1;
                end
                ST_BRK: begin
                    w_break = 1'b1;
                end
                ST_EXT_BRK: begin
                    w_break = 1'b1;
                    w_ext   = 1'b1;
                end
                default: begin
                    w_make = 1'b0;
                end
            endcase
        end
    end

    // Map (ext, code) to its physical key bit; non-direction keys map to none.
    always_comb begin
        w_key_hit = 8'b0;
        case ({w_ext, received_data})
            9'h01D: w_key_hit = 8'b0000_0001;
            9'h01B: w_key_hit = 8'b0000_0010;
            9'h01C: w_key_hit = 8'b0000_0100;
            9'h023: w_key_hit = 8'b0000_1000;
            9'h175: w_key_hit = 8'b0001_0000;
            9'h172: w_key_hit = 8'b0010_0000;
            9'h16B: w_key_hit = 8'b0100_0000;
            9'h174: w_key_hit = 8'b1000_0000;
            default: w_key_hit = 8'b0;
        endcase
    end

    assign w_keys_next = w_make  ? (r_keys | w_key_hit)  :
                         w_break ? (r_keys & ~w_key_hit) : r_keys;
    assign w_dir_cur   = r_keys[3:0] | r_keys[7:4];
    assign w_dir_next  = w_keys_next[3:0] | w_keys_next[7:4];
    // Only a direction going from released to held earns an immediate pulse;
    // typematic repeats and the second key of an already-held direction do not.
    assign w_new_dir   = w_make ? (w_dir_next & ~w_dir_cur) : 4'b0;
    assign w_any_next  = |w_dir_next;
    assign w_expire    = w_any_next && (r_rep_cnt == c_one);
    assign w_ud_both   = w_dir_next[0] & w_dir_next[1];
    assign w_lr_both   = w_dir_next[2] & w_dir_next[3];
    // OR-ing new and repeat pulses gives at most one pulse per direction when
    // both land on the same cycle; opposing pairs cancel each other out.
    assign w_pulse     = (w_new_dir | (w_expire ? w_dir_next : 4'b0)) &
                         ~{w_lr_both, w_lr_both, w_ud_both, w_ud_both};

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idle_cnt  <= '0;
            r_rep_cnt   <= '0;
            r_keys      <= 8'b0;
            r_move      <= 4'b0;
            last_make   <= 8'h00;
            last_ext    <= 1'b0;
            make_strobe <= 1'b0;
        end else begin
            make_strobe <= w_make;
            if (w_make) begin
                last_make <= received_data;
                last_ext  <= w_ext;
            end
            r_keys <= w_keys_next;
            r_move <= w_pulse;

            // Shared repeat timer: a newly held direction restarts the long
            // first delay for everyone; idle with nothing held parks at zero.
            if (|w_new_dir) begin
                r_rep_cnt <= c_first_delay;
            end else if (!w_any_next) begin
                r_rep_cnt <= '0;
            end else if (w_expire) begin
                r_rep_cnt <= c_repeat;
            end else if (r_rep_cnt != '0) begin
                r_rep_cnt <= r_rep_cnt - c_one;
            end

            // Prefix tracking; a stalled prefix is abandoned after the timeout
            // so a lost byte cannot corrupt the next key.
            if (received_data_en) begin
                r_idle_cnt <= '0;
                case (r_state)
                    ST_IDLE: begin
                        if (received_data == 8'hE0) begin
                            r_state <= ST_EXT;
                        end else if (received_data == 8'hF0) begin
                            r_state <= ST_BRK;
                        end
                    end
                    ST_EXT: begin
                        if (received_data == 8'hF0) begin
                            r_state <= ST_EXT_BRK;
                        end else if (received_data != 8'hE0) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end else if (r_state != ST_IDLE) begin
                if (r_idle_cnt == c_timeout_last) begin
                    r_state    <= ST_IDLE;
                    r_idle_cnt <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + c_one;
                end
            end
        end
    end

    assign up_held    = r_keys[0] | r_keys[4];
    assign down_held  = r_keys[1] | r_keys[5];
    assign left_held  = r_keys[2] | r_keys[6];
    assign right_held = r_keys[3] | r_keys[7];
    assign move_up    = r_move[0];
    assign move_down  = r_move[1];
    assign move_left  = r_move[2];
    assign move_right = r_move[3];

endmodule
`default_nettype wire
